// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fq_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and decode-side handshake bundle of the fetch queue.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_instr;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output req_valid, req_addr, out_valid, out_instr, out_pc,
        input  req_ready, rsp_valid, rsp_instr, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_instr, out_pc,
        output req_ready, rsp_valid, rsp_instr, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush, occupancy count and fall-through head read.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited fetch, in-order response tagging, redirect flush/drain.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    fq_state_t       state;
    fq_state_t       state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nx;
    cnt_t            inflight;
    cnt_t            inflight_nx;
    cnt_t            drop_cnt;
    cnt_t            drop_cnt_nx;
    cnt_t            drop_sum;

    logic            req_fire;
    logic            rsp_take;
    logic            out_fire;
    logic [CW:0]     credits_used;

    cnt_t                 data_count;
    logic                 data_full;
    logic                 data_empty;
    logic [XLEN+ILEN-1:0] data_head;
    cnt_t                 tag_count;
    logic                 tag_full;
    logic                 tag_empty;
    logic [XLEN-1:0]      tag_pc;

    assign credits_used  = {1'b0, data_count} + {1'b0, inflight};
    assign bus.req_addr  = fetch_pc;
    assign bus.out_valid = !data_empty && !rst;
    assign bus.out_instr = data_head[ILEN-1:0];
    assign bus.out_pc    = data_head[ILEN +: XLEN];
    assign out_fire      = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            inflight <= inflight_nx;
            drop_cnt <= drop_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        inflight_nx   = inflight;
        drop_cnt_nx   = drop_cnt;
        drop_sum      = '0;
        bus.req_valid = 1'b0;
        rsp_take      = 1'b0;
        req_fire      = 1'b0;

        case (state)
            FETCH: begin
                bus.req_valid = !rst && !bus.redirect && (credits_used < DEPTH_C);
                rsp_take      = bus.rsp_valid && !bus.redirect;
            end
            DRAIN: begin
                if (bus.rsp_valid && !bus.redirect) begin
                    drop_cnt_nx = drop_cnt - cnt_t'(1);
                    if (drop_cnt == cnt_t'(1)) begin
                        state_nx = FETCH;
                    end
                end
            end
            default: state_nx = FETCH;
        endcase

        req_fire = bus.req_valid && bus.req_ready;
        if (req_fire) begin
            fetch_pc_nx = fetch_pc + XLEN'(PC_STEP);
        end
        if (req_fire && !rsp_take) begin
            inflight_nx = inflight + cnt_t'(1);
        end else if (!req_fire && rsp_take) begin
            inflight_nx = inflight - cnt_t'(1);
        end

        // Everything still outstanding becomes stale; a response arriving now is one of them.
        if (bus.redirect) begin
            drop_sum    = drop_cnt + inflight - cnt_t'(bus.rsp_valid);
            fetch_pc_nx = {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight_nx = '0;
            drop_cnt_nx = drop_sum;
            state_nx    = (drop_sum != '0) ? DRAIN : FETCH;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (rsp_take),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (rsp_take),
        .wdata ({tag_pc, bus.rsp_instr}),
        .pop   (out_fire),
        .rdata (data_head),
        .count (data_count),
        .full  (data_full),
        .empty (data_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_take |-> (!data_full || out_fire));
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
        rsp_take |-> !tag_empty);
    a_tag_room: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !tag_full);
    a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
        tag_count == inflight);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1-cycle in-order memory model and output logger.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst;
    logic rsp_hold;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] out_log[$];
    logic [31:0] ins_log[$];

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus_if ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory model: accepts on the edge, answers 1 cycle later in order; shares rst.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (bus_if.rsp_valid) void'(pend.pop_front());
            if (bus_if.req_valid && bus_if.req_ready) begin
                pend.push_back(bus_if.req_addr);
                acc_log.push_back(bus_if.req_addr);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                out_log.push_back(bus_if.out_pc);
                ins_log.push_back(bus_if.out_instr);
            end
        end
        #1;
        bus_if.rsp_valid = !rsp_hold && (pend.size() > 0);
        bus_if.rsp_instr = (pend.size() > 0) ? instr_of(pend[0]) : 32'h0;
    end

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
        ins_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        rsp_hold = 1'b0;
        bus_if.req_ready   = 1'b1;
        bus_if.out_ready   = 1'b1;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = '0;

        // Reset state and first cycle after release
        repeat (2) @(negedge clk);
        check("rst_req_valid", bus_if.req_valid, 0);
        check("rst_out_valid", bus_if.out_valid, 0);
        rst = 1'b0;
        clear_logs();
        #1;
        check("first_req_valid", bus_if.req_valid, 1);
        check("first_req_addr", bus_if.req_addr, 32'h0);

        // Streaming: sequential addresses, in-order output, one per cycle
        repeat (12) @(negedge clk);
        check("stream_acc_n", acc_log.size() >= 6, 1);
        check("stream_out_n", out_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            check("stream_addr", acc_log[i], 32'(i * 4));
            check("stream_pc", out_log[i], 32'(i * 4));
            check("stream_instr", ins_log[i], instr_of(32'(i * 4)));
        end
        base = out_log.size();
        repeat (8) @(negedge clk);
        check("stream_rate", out_log.size() - base, 8);

        // Stall: credits cap requests at DEPTH, head held
        bus_if.out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("stall_acc_n", acc_log.size(), 4);
        check("stall_req_valid", bus_if.req_valid, 0);
        check("stall_out_valid", bus_if.out_valid, 1);
        check("stall_out_pc", bus_if.out_pc, 32'h0);
        repeat (3) @(negedge clk);
        check("stall_hold_pc", bus_if.out_pc, 32'h0);
        check("stall_hold_instr", bus_if.out_instr, instr_of(32'h0));
        bus_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_rel_n", out_log.size(), 4);
        for (int i = 0; i < 4; i++) check("stall_rel_pc", out_log[i], 32'(i * 4));

        // Redirect with three requests outstanding -> drain
        rsp_hold = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        bus_if.req_ready = 1'b0;
        check("redir_acc_n", acc_log.size(), 3);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h100;
        #1;
        check("redir_req_low", bus_if.req_valid, 0);
        @(negedge clk);
        bus_if.redirect  = 1'b0;
        bus_if.req_ready = 1'b1;
        rsp_hold = 1'b0;
        clear_logs();
        #1;
        check("drain_req_low", bus_if.req_valid, 0);
        check("drain_out_low", bus_if.out_valid, 0);
        repeat (3) @(negedge clk);
        check("drain_req_low2", bus_if.req_valid, 0);
        for (int i = 0; i < 20 && !bus_if.out_valid; i++) @(negedge clk);
        check("redir_out_valid", bus_if.out_valid, 1);
        check("redir_out_pc", bus_if.out_pc, 32'h100);
        check("redir_out_instr", bus_if.out_instr, instr_of(32'h100));
        check("redir_first_req", acc_log[0], 32'h100);

        // Unaligned redirect target
        bus_if.req_ready = 1'b0;
        do_reset();
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h203;
        @(negedge clk);
        bus_if.redirect = 1'b0;
        #1;
        check("align_req_valid", bus_if.req_valid, 1);
        check("align_req_addr", bus_if.req_addr, 32'h200);

        // Address wrap at 2^XLEN
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'hFFFF_FFFC;
        bus_if.req_ready   = 1'b1;
        @(negedge clk);
        bus_if.redirect = 1'b0;
        clear_logs();
        #1;
        check("wrap_addr0", bus_if.req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check("wrap_addr1", bus_if.req_addr, 32'h0);
        repeat (4) @(negedge clk);
        check("wrap_pc0", out_log[0], 32'hFFFF_FFFC);
        check("wrap_pc1", out_log[1], 32'h0);

        // Reset with two responses pending
        rsp_hold = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        bus_if.req_ready = 1'b0;
        check("rstmid_acc_n", acc_log.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req_valid", bus_if.req_valid, 0);
        check("rstmid_out_valid", bus_if.out_valid, 0);
        rst = 1'b0;
        rsp_hold = 1'b0;
        clear_logs();
        #1;
        check("rstmid_req_addr", bus_if.req_addr, 32'h0);
        repeat (6) @(negedge clk);
        check("rstmid_no_out", out_log.size(), 0);
        check("rstmid_out_low", bus_if.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, PC and address width (>=16).
REQ-002 Parameter DEPTH, default 4, prefetch entries and max in-flight requests (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, first fetch address.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  out  1  instruction-memory request valid.
REQ-007 req_ready  in  1  memory accepts request.
REQ-008 req_addr  out  XLEN  word-aligned fetch address.
REQ-009 rsp_valid  in  1  response valid, in request order, >=1 cycle after acceptance.
REQ-010 rsp_instr  in  32  returned instruction word.
REQ-011 redirect  in  1  branch/jump taken, restart fetch.
REQ-012 redirect_pc  in  XLEN  new fetch address.
REQ-013 out_valid  out  1  decode-side instruction valid.
REQ-014 out_ready  in  1  decode accepts (low = pipeline stall).
REQ-015 out_instr  out  32  instruction at FIFO head.
REQ-016 out_pc  out  XLEN  PC of out_instr.

Function
REQ-017 FSM states FETCH and DRAIN; reset enters FETCH.
REQ-018 FETCH: req_valid = (fifo_count + inflight < DEPTH) and not redirect; req_addr = fetch_pc.
REQ-019 Request handshake (req_valid & req_ready): fetch_pc += 4 modulo 2^XLEN, inflight += 1, PC pushed to tag queue.
REQ-020 Once asserted, req_valid and req_addr hold until accepted; only redirect or rst may withdraw them.
REQ-021 Non-stale rsp_valid: {tag PC, rsp_instr} written to FIFO, inflight -= 1; out_valid visible next cycle (1-cycle latency).
REQ-022 Request and response in same cycle: inflight unchanged.
REQ-023 Output handshake (out_valid & out_ready): FIFO pops; out_instr/out_pc show next entry next cycle.
REQ-024 out_valid, out_instr, out_pc remain stable while out_valid & ~out_ready.
REQ-025 Credit rule guarantees no FIFO overflow; response into full FIFO is an assertion error, never silent.
REQ-026 Simultaneous push and pop at any occupancy both succeed; count unchanged.
REQ-027 redirect (any state): FIFO and tag queue flushed, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, drop_cnt <= inflight (minus one if a stale rsp_valid arrives that cycle), inflight <= 0, out_valid low next cycle.
REQ-028 After redirect, go to DRAIN if drop_cnt nonzero, else FETCH; first new request no earlier than the cycle after redirect.
REQ-029 DRAIN: req_valid low; each rsp_valid discarded, drop_cnt -= 1; at drop_cnt reaching 0 return to FETCH.
REQ-030 rsp_valid coincident with redirect is stale and discarded.
REQ-031 Output handshake coincident with redirect counts as consumed; rest flushed.
REQ-032 Redirect during DRAIN accumulates: drop_cnt keeps all still-outstanding responses.

Reset
REQ-033 rst high: state FETCH, fetch_pc = RESET_PC, inflight = drop_cnt = 0, FIFO empty, req_valid = out_valid = 0.
REQ-034 Reset mid-operation drops all in-flight responses; memory side is reset by the same rst.
REQ-035 First cycle after rst deasserts: req_valid = 1, req_addr = RESET_PC.

Structure
REQ-036 Package fetch_pkg holds the state enum, ILEN = 32 and PC_STEP = 4.
REQ-037 One sub-module: sync_fifo (parametrised width/depth, count, full/empty), instantiated for instruction FIFO and tag queue.
REQ-038 Counters inflight and drop_cnt are $clog2(DEPTH)+1 bits wide.

Verification
REQ-039 Reset, req_ready=1, 1-cycle memory, out_ready=1 -> addresses 0,4,8,...; out_pc in order, one instruction per cycle steady-state.
REQ-040 out_ready=0, DEPTH=4 -> exactly 4 requests issued, then req_valid=0; out_pc=0 held stable; release -> 0,4,8,12 in order.
REQ-041 Three requests in flight (0,4,8), redirect_pc=0x100 -> DRAIN, three responses dropped, next req_addr=0x100, next out_pc=0x100.
REQ-042 redirect_pc=0x203 -> req_addr=0x200.
REQ-043 fetch_pc=0xFFFFFFFC, XLEN=32 -> following request at 0x00000000.
REQ-044 rst asserted with 2 responses pending -> all outputs reset next cycle; late responses never reach out_valid.
